// File: rtl/sign_extender.sv
// rtl/sign_extender.sv - registered sign/zero extension of an immediate for the ALU operand B mux
module sign_extender #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  In,
    input  logic             S,
    output logic [OUT_W-1:0] Out
);

    logic [OUT_W-1:0] ext;

    generate
        if (OUT_W < IN_W) begin : g_bad_width
            $error("sign_extender: OUT_W must be >= IN_W");
        end else if (OUT_W == IN_W) begin : g_same_width
            // Nothing to extend, so the mode bit is irrelevant here.
            always_comb begin
                ext = In;
            end
        end else begin : g_extend
            localparam int PAD_W = OUT_W - IN_W;
            logic pad_bit;

            // Keeping the pad bit separate means the low bits never depend on S.
            always_comb begin
                pad_bit = S & In[IN_W-1];
                ext     = {{PAD_W{pad_bit}}, In};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            Out <= '0;
        end else begin
            Out <= ext;
        end
    end

endmodule

// File: tb/tb_sign_extender.sv
// tb/tb_sign_extender.sv - self-checking bench for sign_extender
module tb_sign_extender;

    logic        clk;
    logic        reset;
    logic [7:0]  in_r;
    logic        s_r;
    logic [15:0] out_w;

    int checks;
    int fails;

    sign_extender #(.IN_W(8), .OUT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .In    (in_r),
        .S     (s_r),
        .Out   (out_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the value the immediate represents, reinterpreted as 16 bits.
    function automatic logic [15:0] model(input logic [7:0] v, input logic s);
        int value;
        value = int'(v);
        if (s && value >= 128) value = value - 256;
        return 16'(value);
    endfunction

    task automatic step(input logic rst, input logic [7:0] v, input logic s);
        reset = rst;
        in_r  = v;
        s_r   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 8'hFF, 1'b1);
        checks++;
        if (out_w !== 16'h0000) begin
            fails++;
            $display("FAIL reset_clear: got %h want %h", out_w, 16'h0000);
        end
        step(1'b1, 8'hFF, 1'b1);
        checks++;
        if (out_w !== 16'hFFFF) begin
            fails++;
            $display("FAIL reset_release: got %h want %h", out_w, 16'hFFFF);
        end
    endtask

    task automatic test_signed();
        logic [7:0]  vin [4]  = '{8'hFF, 8'h80, 8'h0F, 8'h7F};
        logic [15:0] vexp [4] = '{16'hFFFF, 16'hFF80, 16'h000F, 16'h007F};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vin[i], 1'b1);
            checks++;
            if (out_w !== vexp[i]) begin
                fails++;
                $display("FAIL signed_%0d: in %h got %h want %h", i, vin[i], out_w, vexp[i]);
            end
        end
    endtask

    task automatic test_unsigned();
        logic [7:0]  vin [3]  = '{8'hFF, 8'h0F, 8'h80};
        logic [15:0] vexp [3] = '{16'h00FF, 16'h000F, 16'h0080};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, vin[i], 1'b0);
            checks++;
            if (out_w !== vexp[i]) begin
                fails++;
                $display("FAIL unsigned_%0d: in %h got %h want %h", i, vin[i], out_w, vexp[i]);
            end
        end
    endtask

    task automatic test_latency_hold();
        step(1'b1, 8'h12, 1'b0);
        in_r = 8'hAB;
        s_r  = 1'b1;
        #3;
        checks++;
        if (out_w !== 16'h0012) begin
            fails++;
            $display("FAIL hold_between_edges: got %h want %h", out_w, 16'h0012);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_w !== 16'hFFAB) begin
            fails++;
            $display("FAIL hold_next_edge: got %h want %h", out_w, 16'hFFAB);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vin [3]  = '{8'h01, 8'hFE, 8'hFE};
        logic        vs [3]   = '{1'b1, 1'b1, 1'b0};
        logic [15:0] vexp [3] = '{16'h0001, 16'hFFFE, 16'h00FE};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, vin[i], vs[i]);
            checks++;
            if (out_w !== vexp[i]) begin
                fails++;
                $display("FAIL back_to_back_%0d: got %h want %h", i, out_w, vexp[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic        vr [4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0]  vin [4]  = '{8'h85, 8'h85, 8'h9C, 8'h9C};
        logic        vs [4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] vexp [4] = '{16'hFF85, 16'h0000, 16'hFF9C, 16'h009C};
        for (int i = 0; i < 4; i++) begin
            step(vr[i], vin[i], vs[i]);
            checks++;
            if (out_w !== vexp[i]) begin
                fails++;
                $display("FAIL reset_midstream_%0d: got %h want %h", i, out_w, vexp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  v;
        logic        s;
        logic        r;
        logic [15:0] exp_v;
        for (int i = 0; i < 300; i++) begin
            v = 8'($urandom);
            s = 1'($urandom);
            r = ($urandom_range(0, 7) != 0);
            exp_v = r ? model(v, s) : 16'h0000;
            step(r, v, s);
            checks++;
            if (out_w !== exp_v) begin
                fails++;
                $display("FAIL random_%0d: rst %b in %h s %b got %h want %h", i, r, v, s, out_w, exp_v);
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b0;
        in_r   = 8'h00;
        s_r    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_signed();
        test_unsigned();
        test_latency_hold();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sign_extender.md
Name: sign_extender

Overview:
- Converts an 8-bit immediate into a 16-bit datapath operand for the CPU.
- Performs either sign extension or zero extension, selected by a mode bit.
- Result is registered: one clock of latency, cleared by a synchronous active-low reset.
- Feeds the immediate mux ahead of the ALU operand B.

Parameters:
- IN_W, 8, width of the immediate input In.
- OUT_W, 16, width of the extended output Out. Must satisfy OUT_W >= IN_W; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low (0 = reset). The single clock is clk.
- In  input  IN_W  immediate value to extend.
- S  input  1  mode: 1 = sign-extend (replicate In[IN_W-1]), 0 = zero-extend.
- Out  output  OUT_W  registered extended value.

Behaviour:
- Single clock domain. All state updates occur only on the rising edge of clk.
- Reset:
  - On a rising edge with reset == 0, Out <= 0 (all OUT_W bits cleared).
  - Reset takes priority over all other inputs.
  - reset has no asynchronous effect; deasserting it mid-cycle changes nothing until the next edge.
- Normal operation, on a rising edge with reset == 1:
  - S == 1: Out <= { (OUT_W-IN_W) copies of In[IN_W-1], In }.
  - S == 0: Out <= { (OUT_W-IN_W) zeros, In }.
- Low bits: Out[IN_W-1:0] always equals the sampled In, regardless of S.
- Latency: exactly 1 cycle from sampling of In/S to the value appearing on Out. One new result can be produced every cycle; there is no handshake and no stall.
- Out holds its value between edges. It does not glitch with combinational changes on In or S.
- Degenerate width: if OUT_W == IN_W, Out <= In and S has no effect.
- X handling: if S is X/Z at a sampling edge, the upper bits may be X; the low IN_W bits still equal In.
- Implementation constraints:
  - Purely combinational extension logic followed by a single OUT_W-bit register.
  - No latches.
  - No other state.

Test Plan:
- Reset: drive reset=0 with In=8'hFF, S=1 for one edge -> Out == 16'h0000. Release reset, hold inputs one edge -> Out == 16'hFFFF.
- Signed, negative: In=8'hFF, S=1 -> after next edge Out == 16'hFFFF. Also In=8'h80, S=1 -> 16'hFF80.
- Signed, positive: In=8'h0F, S=1 -> Out == 16'h000F. Also In=8'h7F, S=1 -> 16'h007F.
- Unsigned: In=8'hFF, S=0 -> Out == 16'h00FF. In=8'h0F, S=0 -> Out == 16'h000F. In=8'h80, S=0 -> 16'h0080.
- Latency and hold: change In between edges -> Out unchanged until the next rising edge. Back-to-back per-cycle changes (8'h01/S=1, 8'hFE/S=1, 8'hFE/S=0) -> Out sequence 16'h0001, 16'hFFFE, 16'h00FE on consecutive cycles.
- Reset mid-stream: assert reset=0 on one edge during a back-to-back stream -> Out == 0 for that cycle. Correct extension resumes on the first edge after reset returns to 1.
